// File: rtl/eng_sched_ctrl_pkg.sv
// Shared definitions for the encoding-engine job scheduler:
// engine geometry constants, the controller state enum and the
// job-configuration legality check.
package eng_pkg;

   localparam int W                = 8;   // GF symbol width, kept for consistency with the engine
   localparam int K_MAX            = 8;   // maximum data packets per stripe
   localparam int BM_MULT_UNIT_NUM = 8;   // bitmatrix multiply units in the engine
   localparam int BMU_BM_MUX_SEL_W = 3;   // clog2(K_MAX)
   localparam int STRIPE_CNT_W     = 16;  // stripe counter width
   localparam int BMU_IDX_W        = $clog2(BM_MULT_UNIT_NUM);

   typedef enum logic [2:0] {
      IDLE,
      CFG,
      RUN,
      DRAIN,
      DONE,
      ABORT
   } eng_state_t;

   // A job is legal when 1 <= k <= K_MAX and at least one stripe is requested.
   function automatic logic cfg_legal(input logic [BMU_BM_MUX_SEL_W:0] k,
                                      input logic [STRIPE_CNT_W-1:0]   stripes);
      return (k != '0) && (k <= (BMU_BM_MUX_SEL_W+1)'(K_MAX)) && (stripes != '0);
   endfunction

endpackage

// File: rtl/eng_sched_ctrl_if.sv
// Engine/outbuf side of the scheduler. The controller (master) drives the
// engine control inputs; the engine model (slave) drives the status signals.
// Handshake: eng_data_used and outbuf_eng_wr_ack are single-cycle event
// strobes, each high cycle counts exactly one stripe; cntrl_eng_calc_en is
// the only flow-control signal back to the engine and already folds in
// outbuf_eng_full.
interface eng_sched_ctrl_if;
   import eng_pkg::*;

   logic                                                eng_data_used;
   logic                                                eng_pl_empty;
   logic                                                eng_outbuf_wr_req;
   logic                                                outbuf_eng_wr_ack;
   logic                                                outbuf_eng_full;
   logic                                                cntrl_eng_calc_en;
   logic                                                eng_rstn;
   logic [0:BM_MULT_UNIT_NUM-1][BMU_BM_MUX_SEL_W-1:0]   bmu_bm_mux_sel_reg_arr;

   modport master (
      input  eng_data_used,
      input  eng_pl_empty,
      input  eng_outbuf_wr_req,
      input  outbuf_eng_wr_ack,
      input  outbuf_eng_full,
      output cntrl_eng_calc_en,
      output eng_rstn,
      output bmu_bm_mux_sel_reg_arr
   );

   modport slave (
      output eng_data_used,
      output eng_pl_empty,
      output eng_outbuf_wr_req,
      output outbuf_eng_wr_ack,
      output outbuf_eng_full,
      input  cntrl_eng_calc_en,
      input  eng_rstn,
      input  bmu_bm_mux_sel_reg_arr
   );

endinterface

// File: rtl/eng_sched_sel_gen.sv
// CFG-phase sequencer: writes one BMU column select per cycle,
// sel[i] = i mod k, using a wrapping counter instead of a divider.
module eng_sched_sel_gen
   import eng_pkg::*;
(
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              load,
   input  logic                                              en,
   input  logic [BMU_BM_MUX_SEL_W:0]                         k,
   output logic [0:BM_MULT_UNIT_NUM-1][BMU_BM_MUX_SEL_W-1:0] sel_arr,
   output logic                                              last
);

   logic [BMU_IDX_W-1:0]        idx;
   logic [BMU_BM_MUX_SEL_W-1:0] mod_cnt;
   logic [BMU_BM_MUX_SEL_W:0]   k_m1;

   assign k_m1 = k - 1'b1;
   assign last = en && (idx == BMU_IDX_W'(BM_MULT_UNIT_NUM-1));

   // Walk the BMU index and the modulo counter together while enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         mod_cnt <= '0;
         sel_arr <= '0;
      end else if (load) begin
         idx     <= '0;
         mod_cnt <= '0;
      end else if (en) begin
         sel_arr[idx] <= mod_cnt;
         idx          <= idx + 1'b1;
         mod_cnt      <= ({1'b0, mod_cnt} == k_m1) ? '0 : mod_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/eng_sched_ctrl.sv
// Job-level controller for the encoding engine: programs BMU selects,
// soft-resets the engine, gates calc enable on outbuf backpressure and
// tracks consumed/acknowledged stripes until done, error or abort.
// Optional performance counters are built when ENG_SCHED_PERF_CNT_EN is defined.
module eng_sched_ctrl
   import eng_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BMU_BM_MUX_SEL_W:0] cfg_k,
   input  logic [STRIPE_CNT_W-1:0] cfg_stripes,
   input  logic                    job_start,
   input  logic                    job_abort,
   eng_sched_ctrl_if.master        eng,
   output logic                    job_busy,
   output logic                    job_done,
   output logic                    job_err,
   output logic [STRIPE_CNT_W-1:0] stripes_in_cnt,
   output logic [STRIPE_CNT_W-1:0] stripes_out_cnt,
`ifdef ENG_SCHED_PERF_CNT_EN
   output logic [31:0]             perf_stall_cnt,
   output logic [31:0]             perf_busy_cnt,
`endif
   output eng_state_t              state_dbg
);

   eng_state_t                  state, state_n;
   logic [BMU_BM_MUX_SEL_W:0]   k_q;
   logic [STRIPE_CNT_W-1:0]     stripes_q;
   logic                        abort_cnt;
   logic                        cfg_ok, start_ok, run_or_drain;
   logic                        proto_err, cnt_en, in_last, sel_last;
   logic [0:BM_MULT_UNIT_NUM-1][BMU_BM_MUX_SEL_W-1:0] sel_arr;

   assign cfg_ok       = cfg_legal(cfg_k, cfg_stripes);
   assign start_ok     = (state == IDLE) && job_start && cfg_ok;
   assign run_or_drain = (state == RUN) || (state == DRAIN);
   // Over-consumption, over-acknowledgement, or ack of a stripe never consumed.
   assign proto_err    = run_or_drain &&
                         ((eng.eng_data_used && (stripes_in_cnt == stripes_q)) ||
                          (eng.outbuf_eng_wr_ack &&
                           ((stripes_out_cnt == stripes_q) || (stripes_out_cnt == stripes_in_cnt))));
   assign cnt_en       = run_or_drain && !proto_err && !job_abort;
   assign in_last      = eng.eng_data_used && ((stripes_in_cnt + 1'b1) == stripes_q);

   assign eng.cntrl_eng_calc_en      = run_or_drain && !eng.outbuf_eng_full;
   assign eng.eng_rstn               = !((state == CFG) || (state == ABORT));
   assign eng.bmu_bm_mux_sel_reg_arr = sel_arr;
   assign job_busy                   = (state == CFG) || (state == RUN) || (state == DRAIN);
   assign job_done                   = (state == DONE);
   assign state_dbg                  = state;

   eng_sched_sel_gen u_sel_gen (
      .clk     (clk),
      .rst     (rst),
      .load    (start_ok),
      .en      (state == CFG),
      .k       (k_q),
      .sel_arr (sel_arr),
      .last    (sel_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state: abort beats protocol errors, which beat normal progress.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start_ok) state_n = CFG;
         CFG:     if (job_abort) state_n = ABORT;
                  else if (sel_last) state_n = RUN;
         RUN:     if (job_abort || proto_err) state_n = ABORT;
                  else if (in_last) state_n = DRAIN;
         DRAIN:   if (job_abort || proto_err) state_n = ABORT;
                  else if ((stripes_out_cnt == stripes_q) && eng.eng_pl_empty) state_n = DONE;
         DONE:    state_n = IDLE;
         ABORT:   if (abort_cnt) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // ABORT holds the engine in reset for two cycles; the counter restarts on every entry.
   always_ff @(posedge clk) begin
      if (rst) abort_cnt <= 1'b0;
      else     abort_cnt <= (state == ABORT) ? ~abort_cnt : 1'b0;
   end

   // Job latch, stripe counters and registered error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         k_q             <= '0;
         stripes_q       <= '0;
         stripes_in_cnt  <= '0;
         stripes_out_cnt <= '0;
         job_err         <= 1'b0;
      end else begin
         job_err <= ((state == IDLE) && job_start && !cfg_ok) || (proto_err && !job_abort);
         if (start_ok) begin
            k_q             <= cfg_k;
            stripes_q       <= cfg_stripes;
            stripes_in_cnt  <= '0;
            stripes_out_cnt <= '0;
         end else if (cnt_en) begin
            if (eng.eng_data_used)     stripes_in_cnt  <= stripes_in_cnt + 1'b1;
            if (eng.outbuf_eng_wr_ack) stripes_out_cnt <= stripes_out_cnt + 1'b1;
         end
      end
   end

`ifdef ENG_SCHED_PERF_CNT_EN
   // Saturating stall and busy cycle counters, cleared by a legal start.
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         perf_stall_cnt <= '0;
         perf_busy_cnt  <= '0;
      end else begin
         if (run_or_drain && eng.outbuf_eng_full && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
         if (job_busy && (perf_busy_cnt != '1))
            perf_busy_cnt <= perf_busy_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_eng_sched_ctrl.sv
// Directed bench for eng_sched_ctrl: select programming, backpressure gating,
// illegal configs, abort, protocol error and mid-job reset.
module tb_eng_sched_ctrl;
   import eng_pkg::*;

   localparam int SW = BMU_BM_MUX_SEL_W;
   localparam int N  = BM_MULT_UNIT_NUM;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [SW:0]               cfg_k       = '0;
   logic [STRIPE_CNT_W-1:0]   cfg_stripes = '0;
   logic                      job_start   = 1'b0;
   logic                      job_abort   = 1'b0;
   logic                      job_busy, job_done, job_err;
   logic [STRIPE_CNT_W-1:0]   stripes_in_cnt, stripes_out_cnt;
   eng_state_t                state_dbg;
`ifdef ENG_SCHED_PERF_CNT_EN
   logic [31:0]               perf_stall_cnt, perf_busy_cnt;
`endif

   eng_sched_ctrl_if bus ();

   eng_sched_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_k           (cfg_k),
      .cfg_stripes     (cfg_stripes),
      .job_start       (job_start),
      .job_abort       (job_abort),
      .eng             (bus.master),
      .job_busy        (job_busy),
      .job_done        (job_done),
      .job_err         (job_err),
      .stripes_in_cnt  (stripes_in_cnt),
      .stripes_out_cnt (stripes_out_cnt),
`ifdef ENG_SCHED_PERF_CNT_EN
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_busy_cnt   (perf_busy_cnt),
`endif
      .state_dbg       (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [SW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_sels(input int k);
      for (int i = 0; i < N; i++) exp_q.push_back(SW'(i % k));
   endtask

   task automatic check_sels(input string tag);
      logic [SW-1:0] e;
      for (int i = 0; i < N; i++) begin
         e = exp_q.pop_front();
         check($sformatf("%s[%0d]", tag, i), 32'(bus.bmu_bm_mux_sel_reg_arr[i]), 32'(e));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic used, input logic ack);
      bus.eng_data_used     = used;
      bus.outbuf_eng_wr_ack = ack;
      tick();
      bus.eng_data_used     = 1'b0;
      bus.outbuf_eng_wr_ack = 1'b0;
   endtask

   task automatic start_job(input int k, input int s);
      cfg_k       = (SW+1)'(k);
      cfg_stripes = STRIPE_CNT_W'(s);
      job_start   = 1'b1;
      tick();
      job_start   = 1'b0;
   endtask

   // Legal start, then the CFG phase: rstn low for N cycles, calc_en on right after.
   task automatic start_legal_job(input int k, input int s);
      int c;
      push_sels(k);
      start_job(k, s);
      check("busy_in_cfg", 32'(job_busy), 32'd1);
      c = 0;
      while (bus.eng_rstn == 1'b0 && c < 20) begin
         c++;
         tick();
      end
      check("cfg_rstn_low_cycles", c, N);
      check("first_calc_en", 32'(bus.cntrl_eng_calc_en), 32'd1);
      check("state_run", 32'(state_dbg), 32'(RUN));
      check_sels("sel");
   endtask

   task automatic wait_done(input string tag);
      int d;
      d = 0;
      repeat (6) begin
         tick();
         if (job_done) d++;
      end
      check({tag, "_done_pulses"}, d, 1);
      check({tag, "_idle"}, 32'(state_dbg), 32'(IDLE));
      check({tag, "_busy"}, 32'(job_busy), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_calc_en"}, 32'(bus.cntrl_eng_calc_en), 32'd0);
      check({tag, "_eng_rstn"}, 32'(bus.eng_rstn), 32'd1);
      check({tag, "_sels_zero"}, 32'(bus.bmu_bm_mux_sel_reg_arr == '0), 32'd1);
      check({tag, "_busy"}, 32'(job_busy), 32'd0);
      check({tag, "_done"}, 32'(job_done), 32'd0);
      check({tag, "_err"}, 32'(job_err), 32'd0);
      check({tag, "_in_cnt"}, 32'(stripes_in_cnt), 32'd0);
      check({tag, "_out_cnt"}, 32'(stripes_out_cnt), 32'd0);
      check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int low, c, done_seen;
      bus.eng_data_used     = 1'b0;
      bus.eng_pl_empty      = 1'b1;
      bus.eng_outbuf_wr_req = 1'b0;
      bus.outbuf_eng_wr_ack = 1'b0;
      bus.outbuf_eng_full   = 1'b0;

      repeat (3) tick();
      check_reset_vals("reset");
      rst = 1'b0;
      tick();
      check("idle_after_reset", 32'(state_dbg), 32'(IDLE));

      // Happy path with a simultaneous consume+ack cycle.
      start_legal_job(3, 4);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("simul_in_cnt", 32'(stripes_in_cnt), 32'd2);
      check("simul_out_cnt", 32'(stripes_out_cnt), 32'd1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("state_drain", 32'(state_dbg), 32'(DRAIN));
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      wait_done("happy");
      check("happy_in_cnt", 32'(stripes_in_cnt), 32'd4);
      check("happy_out_cnt", 32'(stripes_out_cnt), 32'd4);

      // Backpressure: outbuf full for 5 RUN cycles, K at its maximum.
      start_legal_job(8, 2);
      low = 0;
      for (int j = 0; j < 9; j++) begin
         bus.outbuf_eng_full = (j >= 2 && j < 7);
         #1;
         if (!bus.cntrl_eng_calc_en) low++;
         tick();
      end
      bus.outbuf_eng_full = 1'b0;
      check("bp_calc_en_low_cycles", low, 5);
`ifdef ENG_SCHED_PERF_CNT_EN
      check("perf_stall_cnt", perf_stall_cnt, 32'd5);
`endif
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      wait_done("bp");
      check("bp_in_cnt", 32'(stripes_in_cnt), 32'd2);
      check("bp_out_cnt", 32'(stripes_out_cnt), 32'd2);

      // Illegal configs: error pulse, stay idle, selects untouched (last job k=8).
      push_sels(8);
      start_job(0, 4);
      check("k0_err", 32'(job_err), 32'd1);
      check("k0_busy", 32'(job_busy), 32'd0);
      check("k0_state", 32'(state_dbg), 32'(IDLE));
      tick();
      check("k0_err_cleared", 32'(job_err), 32'd0);
      check_sels("k0_sel_kept");
      push_sels(8);
      start_job(9, 4);
      check("k9_err", 32'(job_err), 32'd1);
      check("k9_busy", 32'(job_busy), 32'd0);
      tick();
      check_sels("k9_sel_kept");
      start_job(2, 0);
      check("s0_err", 32'(job_err), 32'd1);
      check("s0_state", 32'(state_dbg), 32'(IDLE));
      tick();

      // Abort in DRAIN after 2 of 4 acks.
      start_legal_job(2, 4);
      repeat (4) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("abort_pre_state", 32'(state_dbg), 32'(DRAIN));
      job_abort = 1'b1;
      tick();
      job_abort = 1'b0;
      check("abort_err", 32'(job_err), 32'd0);
      check("abort_state", 32'(state_dbg), 32'(ABORT));
      check("abort_calc_en", 32'(bus.cntrl_eng_calc_en), 32'd0);
      c = 0;
      done_seen = 0;
      while (bus.eng_rstn == 1'b0 && c < 10) begin
         c++;
         if (job_done) done_seen++;
         tick();
      end
      check("abort_rstn_low_cycles", c, 2);
      check("abort_no_done", done_seen + 32'(job_done), 0);
      check("abort_idle", 32'(state_dbg), 32'(IDLE));

      // Extra consume after the stripe count is reached.
      start_legal_job(4, 1);
      step(1'b1, 1'b0);
      check("extra_pre_state", 32'(state_dbg), 32'(DRAIN));
      step(1'b1, 1'b0);
      check("extra_err", 32'(job_err), 32'd1);
      check("extra_state", 32'(state_dbg), 32'(ABORT));
      check("extra_in_cnt", 32'(stripes_in_cnt), 32'd1);
      c = 0;
      while (bus.eng_rstn == 1'b0 && c < 10) begin
         c++;
         tick();
      end
      check("extra_rstn_low_cycles", c, 2);
      check("extra_idle", 32'(state_dbg), 32'(IDLE));

      // Reset in RUN with two stripes consumed, then a clean job.
      start_legal_job(5, 4);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check("rst_pre_in_cnt", 32'(stripes_in_cnt), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("midrst");
      start_legal_job(3, 1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      wait_done("post_rst");
      check("post_rst_in_cnt", 32'(stripes_in_cnt), 32'd1);
      check("post_rst_out_cnt", 32'(stripes_out_cnt), 32'd1);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
